// File: rtl/shift_rgst.sv
// Parallel-load / serial-shift register with saturating shift counter and word-complete flag.
// Optional rotate mode (input rot) is built when SHIFT_RGST_ROT_EN is defined.
module shift_rgst #(
    parameter int           W         = 8,
    parameter logic [W-1:0] IV        = '0,
    parameter bit           MSB_FIRST = 1'b1,
    localparam int          CW        = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [W-1:0]  d,
    input  logic          ld,
    input  logic          clr,
    input  logic          sh_en,
    input  logic          sin,
`ifdef SHIFT_RGST_ROT_EN
    input  logic          rot,
`endif
    output logic [W-1:0]  q,
    output logic          sout,
    output logic [CW-1:0] cnt,
    output logic          done
);

    localparam logic [CW-1:0] CNT_FULL = CW'(W);

    logic         rot_sel;
    logic         fill_bit;
    logic [W-1:0] q_shift;
    logic [CW-1:0] cnt_inc;

`ifdef SHIFT_RGST_ROT_EN
    assign rot_sel = rot;
`else
    assign rot_sel = 1'b0;
`endif

    // The bit leaving the register is recycled into the vacated slot when rotating.
    assign sout     = MSB_FIRST ? q[W-1] : q[0];
    assign fill_bit = rot_sel ? sout : sin;

    always_comb begin
        q_shift = q;
        if (MSB_FIRST) begin
            q_shift = {q[W-2:0], fill_bit};
        end else begin
            q_shift = {fill_bit, q[W-1:1]};
        end
    end

    // Counter saturates so done stays asserted while shifting continues.
    assign cnt_inc = (cnt == CNT_FULL) ? cnt : cnt + CW'(1);
    assign done    = (cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            q   <= IV;
            cnt <= '0;
        end else if (clr) begin
            q   <= IV;
            cnt <= '0;
        end else if (ld) begin
            q   <= d;
            cnt <= '0;
        end else if (sh_en) begin
            q   <= q_shift;
            cnt <= cnt_inc;
        end
    end

endmodule

// File: tb/tb_shift_rgst.sv
// Self-checking bench for shift_rgst: MSB-first and LSB-first instances share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_shift_rgst;

    localparam int          W    = 8;
    localparam int          CW   = $clog2(W + 1);
    localparam logic [7:0]  IV_M = 8'hC3;
    localparam logic [7:0]  IV_L = 8'h5A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b, clr, ld, sh_en, sin, rot;
    logic [7:0]    d;
    logic [7:0]    q_m, q_l;
    logic [CW-1:0] cnt_m, cnt_l;
    logic          sout_m, sout_l, done_m, done_l;

    shift_rgst #(.W(W), .IV(IV_M), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst_b(rst_b), .d(d), .ld(ld), .clr(clr), .sh_en(sh_en), .sin(sin),
`ifdef SHIFT_RGST_ROT_EN
        .rot(rot),
`endif
        .q(q_m), .sout(sout_m), .cnt(cnt_m), .done(done_m)
    );

    shift_rgst #(.W(W), .IV(IV_L), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst_b(rst_b), .d(d), .ld(ld), .clr(clr), .sh_en(sh_en), .sin(sin),
`ifdef SHIFT_RGST_ROT_EN
        .rot(rot),
`endif
        .q(q_l), .sout(sout_l), .cnt(cnt_l), .done(done_l)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: register value as an integer word, counter as a plain int.
    logic [7:0] mq_m, mq_l;
    int         mc_m, mc_l;

    task automatic model_edge();
        logic rot_eff, fm, fl;
`ifdef SHIFT_RGST_ROT_EN
        rot_eff = rot;
`else
        rot_eff = 1'b0;
`endif
        if (!rst_b || clr) begin
            mq_m = IV_M; mq_l = IV_L; mc_m = 0; mc_l = 0;
        end else if (ld) begin
            mq_m = d; mq_l = d; mc_m = 0; mc_l = 0;
        end else if (sh_en) begin
            fm   = rot_eff ? mq_m[7] : sin;
            fl   = rot_eff ? mq_l[0] : sin;
            mq_m = 8'((mq_m * 2) + fm);
            mq_l = 8'((mq_l / 2) + (fl ? 128 : 0));
            mc_m = (mc_m < W) ? mc_m + 1 : W;
            mc_l = (mc_l < W) ? mc_l + 1 : W;
        end
    endtask

    task automatic check_all();
        check("q_msb",    32'(q_m),    32'(mq_m));
        check("cnt_msb",  32'(cnt_m),  32'(mc_m));
        check("done_msb", 32'(done_m), 32'(mc_m == W));
        check("sout_msb", 32'(sout_m), 32'(mq_m[7]));
        check("q_lsb",    32'(q_l),    32'(mq_l));
        check("cnt_lsb",  32'(cnt_l),  32'(mc_l));
        check("done_lsb", 32'(done_l), 32'(mc_l == W));
        check("sout_lsb", 32'(sout_l), 32'(mq_l[0]));
    endtask

    // One clock: check at negedge, drive, take the edge, update model, settle 1 time unit.
    task automatic cyc(input logic r, input logic c, input logic l, input logic s,
                       input logic si, input logic ro, input logic [7:0] dd);
        @(negedge clk);
        check_all();
        rst_b = r; clr = c; ld = l; sh_en = s; sin = si; rot = ro; d = dd;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    logic [7:0] pat;
    logic [7:0] rx_bits;

    initial begin
        rst_b = 1'b0; clr = 1'b0; ld = 1'b0; sh_en = 1'b0; sin = 1'b0; rot = 1'b0; d = 8'h00;
        @(posedge clk);
        model_edge();
        #1;
        check("rst_q_msb", 32'(q_m),   32'(IV_M));
        check("rst_q_lsb", 32'(q_l),   32'(IV_L));
        check("rst_cnt",   32'(cnt_m), 32'd0);
        check("rst_done",  32'(done_m), 32'd0);

        // Serial out, MSB first
        pat = 8'hA5;
        cyc(1, 0, 1, 0, 0, 0, 8'hA5);
        for (int i = 0; i < 8; i++) begin
            check("ser_sout", 32'(sout_m), 32'(pat[7-i]));
            cyc(1, 0, 0, 1, 1, 0, 8'h00);
        end
        check("ser_q",    32'(q_m),    32'hFF);
        check("ser_cnt",  32'(cnt_m),  32'd8);
        check("ser_done", 32'(done_m), 32'd1);

        // Serial in, LSB first
        rx_bits = 8'b0101_0011;   // bit i is the i-th bit shifted in
        cyc(1, 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            check("rx_done_early", 32'(done_l), 32'd0);
            cyc(1, 0, 0, 1, rx_bits[i], 0, 8'h00);
        end
        check("rx_q",    32'(q_l),    32'h53);
        check("rx_done", 32'(done_l), 32'd1);
        cyc(1, 0, 0, 1, 0, 0, 8'h00);
        check("rx9_q",    32'(q_l),    32'h29);
        check("rx9_cnt",  32'(cnt_l),  32'd8);
        check("rx9_done", 32'(done_l), 32'd1);

        // Priority
        cyc(1, 0, 1, 1, 1, 0, 8'h3C);
        check("pri_ld_q",   32'(q_m),   32'h3C);
        check("pri_ld_cnt", 32'(cnt_m), 32'd0);
        cyc(1, 1, 1, 0, 0, 0, 8'h77);
        check("pri_clr_q_msb", 32'(q_m),   32'(IV_M));
        check("pri_clr_q_lsb", 32'(q_l),   32'(IV_L));
        check("pri_clr_cnt",   32'(cnt_l), 32'd0);

        // Mid-operation reset
        cyc(1, 0, 1, 0, 0, 0, 8'hA5);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 1, 1, 0, 8'h00);
        check("mid_cnt_pre", 32'(cnt_m), 32'd3);
        cyc(0, 0, 0, 1, 1, 0, 8'h00);
        check("mid_q",    32'(q_m),    32'(IV_M));
        check("mid_cnt",  32'(cnt_m),  32'd0);
        check("mid_done", 32'(done_m), 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        check("mid_hold_q",   32'(q_m),   32'(IV_M));
        check("mid_hold_cnt", 32'(cnt_m), 32'd0);

        // Reset driven between edges must not act until the next rising edge
        cyc(1, 0, 1, 0, 0, 0, 8'hA5);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0, 1, 0, 0, 8'h00);
        @(negedge clk);
        check_all();
        rst_b = 1'b0; clr = 1'b0; ld = 1'b0; sh_en = 1'b0;
        #2;
        check("async_q",    32'(q_m),    32'h00);
        check("async_cnt",  32'(cnt_m),  32'd8);
        check("async_done", 32'(done_m), 32'd1);
        @(posedge clk);
        model_edge();
        #1;
        check("async_edge_q",    32'(q_m),    32'(IV_M));
        check("async_edge_done", 32'(done_m), 32'd0);

`ifdef SHIFT_RGST_ROT_EN
        cyc(1, 0, 1, 0, 0, 0, 8'h81);
        cyc(1, 0, 0, 1, 0, 1, 8'h00);
        check("rot1_q",   32'(q_m),   32'h03);
        check("rot1_cnt", 32'(cnt_m), 32'd1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 1, 0, 1, 8'h00);
        check("rot8_q",    32'(q_m),    32'h81);
        check("rot8_done", 32'(done_m), 32'd1);
        check("rot8_q_lsb", 32'(q_l),   32'h81);
`endif

        // Randomized traffic, weighted toward long shift runs
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) != 0),
                ($urandom_range(0, 23) == 0),
                ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 3) != 0),
                1'($urandom),
                1'($urandom),
                8'($urandom));
        end
        @(negedge clk);
        check_all();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
